// File: rtl/audio_delay_param.sv
// ---------------------------------------------------------------------------
// audio_delay_param
//   Parametrised mono echo/delay. Each accepted input sample runs through an
//   FSM (IDLE -> READ -> WAIT -> MIX -> WRITE) that reads the delayed sample
//   from an internal dual-port RAM, then mixes dry and wet paths. It also
//   writes dry plus saturated feedback back into the RAM. Port A reads and
//   port B writes. RAM locations that have not been written since reset
//   read as silence.
//
//   Optional feature macro: DELAY_SMOOTH_EN
//     defined   : delay_cur steps by one sample toward the rate-pot target
//                 on each accepted sample (no zipper clicks)
//     undefined : delay_cur jumps to the target on every accepted sample
//
// Ports
//   clk               system clock
//   rst_n             synchronous active-low reset
//   pot_wet           wet/dry mix, all-ones means fully wet
//   pot_rate          delay time, higher value gives a shorter delay
//   pot_feedback      feedback gain (pot / 2**POT_W)
//   sample_in         signed input sample
//   sample_in_valid   one-cycle input strobe
//   sample_out        signed mixed output sample
//   sample_out_valid  one-cycle output strobe, RD_LAT+3 cycles after accept
//   busy              high while a sample is being processed
//   overrun           sticky flag: an input arrived while busy and was dropped
//   delay_cur         delay in samples applied to the current sample
// ---------------------------------------------------------------------------
module audio_delay_param #(
    parameter int SAMPLE_W   = 16,
    parameter int ADDR_W     = 16,
    parameter int POT_W      = 10,
    parameter int TIME_SHIFT = 6,
    parameter int RD_LAT     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [POT_W-1:0]           pot_wet,
    input  logic [POT_W-1:0]           pot_rate,
    input  logic [POT_W-1:0]           pot_feedback,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_in_valid,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_out_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic [ADDR_W-1:0]          delay_cur
);

    localparam int PROD_W = SAMPLE_W + POT_W + 3;
    localparam int CNT_W  = $clog2(RD_LAT) + 1;

    localparam logic [POT_W:0]    UNITY  = {1'b1, {POT_W{1'b0}}};
    localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_MAX  = '1;
    localparam logic [ADDR_W:0]   T_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_MIX,
        S_WRITE
    } state_t;

    // Clamp a wide signed value into the sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat_sample(
        input logic signed [PROD_W-1:0] v
    );
        logic signed [PROD_W-1:0] hi;
        logic signed [PROD_W-1:0] lo;
        hi = PROD_W'($signed({1'b0, {(SAMPLE_W-1){1'b1}}}));
        lo = PROD_W'($signed({1'b1, {(SAMPLE_W-1){1'b0}}}));
        if (v > hi) begin
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (v < lo) begin
            return {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
        return SAMPLE_W'(v);
    endfunction

    // Remove the pot gain scaling (floor division by 2**POT_W).
    function automatic logic signed [PROD_W-1:0] scale_down(
        input logic signed [PROD_W-1:0] v
    );
        return v >>> POT_W;
    endfunction

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill;
    logic              init;
    logic [ADDR_W-1:0] rd_addr;
    logic              accept;
    logic              wr_en;

    logic [POT_W:0]    span;
    logic [ADDR_W:0]   target_full;
    logic [ADDR_W-1:0] target;

    logic signed [SAMPLE_W-1:0] mem [2**ADDR_W];
    logic signed [SAMPLE_W-1:0] rd_pipe [RD_LAT];

    logic signed [SAMPLE_W-1:0] dry_p0;
    logic [POT_W:0]             gw_p0;
    logic [POT_W-1:0]           gf_p0;
    logic signed [SAMPLE_W-1:0] mix_p2;
    logic signed [SAMPLE_W-1:0] din_p2;

    logic signed [SAMPLE_W-1:0] dly;
    logic signed [PROD_W-1:0]   dry_x;
    logic signed [PROD_W-1:0]   dly_x;
    logic signed [PROD_W-1:0]   gw_x;
    logic signed [PROD_W-1:0]   gd_x;
    logic signed [PROD_W-1:0]   gf_x;
    logic signed [PROD_W-1:0]   mix_sum;
    logic signed [PROD_W-1:0]   din_sum;

    assign busy   = (state != S_IDLE);
    assign accept = (state == S_IDLE) && sample_in_valid;
    // A reset arriving in WRITE must also suppress the RAM write.
    assign wr_en  = (state == S_WRITE) && rst_n;

    // Delay target from the rate pot: ((2**POT_W - rate) << TIME_SHIFT) - 1.
    always_comb begin
        span        = UNITY - {1'b0, pot_rate};
        target_full = (ADDR_W+1)'(span) << TIME_SHIFT;
        target      = ADDR_W'(target_full - T_ONE);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (sample_in_valid) state_nx = S_READ;
            S_READ:  state_nx = S_WAIT;
            S_WAIT:  if (wait_cnt == C_LAST) state_nx = S_MIX;
            S_MIX:   state_nx = S_WRITE;
            S_WRITE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Control registers and outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt         <= '0;
            wr_ptr           <= '0;
            fill             <= '0;
            init             <= 1'b1;
            delay_cur        <= A_ONE;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            sample_out_valid <= 1'b0;
            if (sample_in_valid && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                if (init) begin
                    delay_cur <= target;
                    init      <= 1'b0;
                end else begin
`ifdef DELAY_SMOOTH_EN
                    if (delay_cur < target) begin
                        delay_cur <= delay_cur + A_ONE;
                    end else if (delay_cur > target) begin
                        delay_cur <= delay_cur - A_ONE;
                    end
`else
                    delay_cur <= target;
`endif
                end
            end
            case (state)
                S_READ: wait_cnt <= '0;
                S_WAIT: wait_cnt <= wait_cnt + C_ONE;
                S_WRITE: begin
                    wr_ptr           <= wr_ptr + A_ONE;
                    if (fill != A_MAX) fill <= fill + A_ONE;
                    sample_out       <= mix_p2;
                    sample_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Delay RAM: registered read with RD_LAT cycles of latency
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din_p2;
        rd_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Mix arithmetic; the fill guard hides stale RAM contents after reset.
    always_comb begin
        dly     = (delay_cur > fill) ? '0 : rd_pipe[RD_LAT-1];
        dry_x   = PROD_W'(dry_p0);
        dly_x   = PROD_W'(dly);
        gw_x    = $signed(PROD_W'(gw_p0));
        gd_x    = $signed(PROD_W'(UNITY - gw_p0));
        gf_x    = $signed(PROD_W'(gf_p0));
        mix_sum = dry_x * gd_x + dly_x * gw_x;
        din_sum = dry_x + scale_down(dly_x * gf_x);
    end

    // Stage p0: sample and pots latched on accept
    // Stage p1: read address issued in READ
    // Stage p2: mix and feedback results captured in MIX
    always_ff @(posedge clk) begin
        if (accept) begin
            dry_p0 <= sample_in;
            gw_p0  <= (pot_wet == '1) ? UNITY : {1'b0, pot_wet};
            gf_p0  <= pot_feedback;
        end
        if (state == S_READ) begin
            rd_addr <= wr_ptr - delay_cur;
        end
        if (state == S_MIX) begin
            mix_p2 <= SAMPLE_W'(scale_down(mix_sum));
            din_p2 <= sat_sample(din_sum);
        end
    end

endmodule

// File: tb/tb_audio_delay_param.sv
`timescale 1ns/1ps
module tb_audio_delay_param;

    localparam int SW = 16;
    localparam int AW = 16;
    localparam int PW = 10;
    localparam int TS = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [PW-1:0]        pot_wet = '0;
    logic [PW-1:0]        pot_rate = '0;
    logic [PW-1:0]        pot_feedback = '0;
    logic signed [SW-1:0] sample_in = '0;
    logic                 sample_in_valid = 1'b0;
    logic signed [SW-1:0] sample_out;
    logic                 sample_out_valid;
    logic                 busy;
    logic                 overrun;
    logic [AW-1:0]        delay_cur;

    int checks = 0;
    int failures = 0;

    // Reference model state: every value stored in the delay line since reset.
    longint hist[$];
    int     m_delay = 1;
    bit     m_init = 1'b1;

    audio_delay_param #(
        .SAMPLE_W(SW), .ADDR_W(AW), .POT_W(PW), .TIME_SHIFT(TS), .RD_LAT(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pot_wet(pot_wet),
        .pot_rate(pot_rate),
        .pot_feedback(pot_feedback),
        .sample_in(sample_in),
        .sample_in_valid(sample_in_valid),
        .sample_out(sample_out),
        .sample_out_valid(sample_out_valid),
        .busy(busy),
        .overrun(overrun),
        .delay_cur(delay_cur)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int target_of(input int rate);
        return (((1 << PW) - rate) * (1 << TS) - 1) % (1 << AW);
    endfunction

    // Apply the echo rules to one accepted sample and return the expected output.
    task automatic model_accept(input longint s, output longint exp_out);
        longint dly, gw, gf, n;
        int t;
        t = target_of(int'(pot_rate));
        if (m_init) begin
            m_delay = t;
            m_init  = 1'b0;
        end else begin
`ifdef DELAY_SMOOTH_EN
            if (m_delay < t) m_delay++;
            else if (m_delay > t) m_delay--;
`else
            m_delay = t;
`endif
        end
        n   = hist.size();
        dly = (m_delay > n) ? 0 : hist[n - m_delay];
        gw  = (pot_wet == '1) ? 1024 : longint'(pot_wet);
        gf  = longint'(pot_feedback);
        exp_out = (s * (1024 - gw) + dly * gw) >>> PW;
        hist.push_back(sat16(s + ((dly * gf) >>> PW)));
    endtask

    task automatic pulse(input logic signed [SW-1:0] s);
        @(negedge clk);
        sample_in       = s;
        sample_in_valid = 1'b1;
        @(negedge clk);
        sample_in_valid = 1'b0;
    endtask

    task automatic collect(input longint exp, input int lat0, input string tag,
                           output longint got);
        int lat;
        lat = lat0;
        while (!sample_out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 5);
        got = sample_out;
        chk({tag, "_out"}, got, exp);
        chk({tag, "_delay"}, delay_cur, m_delay);
        @(negedge clk);
        chk({tag, "_pulse"}, sample_out_valid, 0);
    endtask

    task automatic do_sample(input logic signed [SW-1:0] s, input string tag,
                             output longint got);
        longint e;
        pulse(s);
        model_accept(s, e);
        chk({tag, "_busy"}, busy, 1);
        collect(e, 0, tag, got);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        sample_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        m_init  = 1'b1;
        m_delay = 1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out"}, sample_out, 0);
        chk({tag, "_vld"}, sample_out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_delay"}, delay_cur, 1);
    endtask

    initial begin
        longint got;
        longint e;
        bit     seen;
        logic signed [SW-1:0] s;

        // Reset values
        do_reset();
        chk_reset_state("rst");

        // Impulse with shortest delay, fully wet, no feedback
        pot_rate = 10'd1023; pot_wet = 10'd1023; pot_feedback = 10'd0;
        for (int i = 0; i < 70; i++) begin
            s = (i == 0) ? 16'sh4000 : 16'sh0000;
            do_sample(s, "t1", got);
            if (i == 63) chk("t1_echo63", got, 16'h4000);
            else if (i == 62 || i == 64) chk("t1_silence", got, 0);
        end

        // Fully dry output is bit-exact with the input
        pot_wet = 10'd0;
        for (int i = 0; i < 40; i++) begin
            pot_feedback = 10'($urandom_range(0, 1023));
            s = 16'($urandom);
            do_sample(s, "t2", got);
            chk("t2_bitexact", got, s);
        end

        // Feedback halves each repeat
        do_reset();
        pot_rate = 10'd1023; pot_wet = 10'd1023; pot_feedback = 10'd512;
        for (int i = 0; i < 253; i++) begin
            s = (i == 0) ? 16'sh4000 : 16'sh0000;
            do_sample(s, "t3", got);
            if (i == 63)  chk("t3_echo63", got, 16'h4000);
            if (i == 126) chk("t3_echo126", got, 16'h2000);
            if (i == 189) chk("t3_echo189", got, 16'h1000);
            if (i == 252) chk("t3_echo252", got, 16'h0800);
        end

        // Feedback saturation, positive then negative full scale
        do_reset();
        pot_rate = 10'd1023; pot_wet = 10'd1023; pot_feedback = 10'd1023;
        for (int i = 0; i < 130; i++) begin
            do_sample(16'sh7FFF, "t4p", got);
            chk("t4p_nonneg", (got < 0) ? 1 : 0, 0);
            if (i == 126) chk("t4p_clamp", got, 32767);
        end
        do_reset();
        for (int i = 0; i < 130; i++) begin
            do_sample(-16'sh8000, "t4n", got);
            chk("t4n_nonpos", (got > 0) ? 1 : 0, 0);
            if (i == 126) chk("t4n_clamp", got, -32768);
        end

        // Overrun: second strobe two cycles after the first is dropped
        do_reset();
        pot_rate = 10'd1023; pot_wet = 10'd512; pot_feedback = 10'd300;
        s = 16'sh1357;
        pulse(s);
        model_accept(s, e);
        @(negedge clk);
        sample_in       = 16'sh2468;
        sample_in_valid = 1'b1;
        @(negedge clk);
        sample_in_valid = 1'b0;
        chk("t5_ovr_set", overrun, 1);
        collect(e, 2, "t5a", got);
        repeat (10) @(negedge clk);
        chk("t5_ovr_hold", overrun, 1);
        do_sample(16'sh0777, "t5b", got);
        chk("t5_ovr_hold2", overrun, 1);

        // Reset while in MIX aborts the sample
        pulse(16'sh3333);
        repeat (3) @(negedge clk);
        chk("t5_busy_mix", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        m_init  = 1'b1;
        m_delay = 1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sample_out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("t5_no_vld", seen, 0);
        chk_reset_state("t5rst");

        // Randomized pots and samples
        for (int i = 0; i < 150; i++) begin
            pot_rate     = 10'($urandom_range(1020, 1023));
            pot_wet      = 10'($urandom_range(0, 1023));
            pot_feedback = 10'($urandom_range(0, 1023));
            if (i % 17 == 0) pot_wet = 10'd1023;
            do_sample(16'($urandom), "rnd", got);
        end

        // Rate pot step 1023 -> 1022 (target 63 -> 127)
        do_reset();
        pot_rate = 10'd1023; pot_wet = 10'd700; pot_feedback = 10'd200;
        do_sample(16'($urandom), "t6i", got);
        chk("t6_init", delay_cur, 63);
        pot_rate = 10'd1022;
        for (int k = 1; k <= 70; k++) begin
            do_sample(16'($urandom), "t6", got);
`ifdef DELAY_SMOOTH_EN
            chk("t6_step", delay_cur, (63 + k > 127) ? 127 : 63 + k);
`else
            chk("t6_jump", delay_cur, 127);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
